pad_dir_sched: RTL

Half-duplex direction scheduler for a bank of registered bidirectional pads (`pad_iobuf_reg` instances sharing one `oe`). It arbitrates between a transmit requester and a receive requester and sequences `pad_oe`/`pad_o`. It inserts a bus-turnaround gap on every direction change and tags returning input samples with a valid flag that is aligned to the pad input-register latency. It sits between protocol engines and the pad ring.

---
 rtl/pad_dir_sched_pkg.sv | 37 +++
 rtl/pad_dir_sched_if.sv | 30 +++
 rtl/pad_valid_pipe.sv | 44 ++++
 rtl/pad_dir_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pad_dir_sched_pkg.sv
// Shared types and defaults for the half-duplex pad direction scheduler.
// Benches at the pad level pick up TURN_DEF/IN_LAT_DEF from here.
package pad_dir_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_TX   = 2'd2,
    ST_RX   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_TX   = 2'd1,
    DIR_RX   = 2'd2
  } dir_t;

  localparam int TURN_DEF   = 2;
  localparam int IN_LAT_DEF = 2;
  localparam int TURN_CNT_W = 4;

  // Both pending: take the direction opposite the last one (TX when none yet).
  function automatic dir_t pick_dir(input logic tx_req, input logic rx_req, input dir_t last_dir);
    dir_t dir;
    if (tx_req && rx_req) begin
      dir = (last_dir == DIR_TX) ? DIR_RX : DIR_TX;
    end else if (tx_req) begin
      dir = DIR_TX;
    end else if (rx_req) begin
      dir = DIR_RX;
    end else begin
      dir = DIR_NONE;
    end
    return dir;
  endfunction

endpackage

// File: rtl/pad_dir_sched_if.sv
// Requester-side bus of the pad direction scheduler: TX/RX request, grant and data.
// master = protocol engine side, slave = scheduler side.
interface pad_dir_sched_if #(
  parameter int WIDTH = 8,
  parameter int LENW  = 8
);

  logic             tx_req;
  logic [LENW-1:0]  tx_len;
  logic             tx_gnt;
  logic [WIDTH-1:0] tx_data;
  logic             tx_rd;

  logic             rx_req;
  logic [LENW-1:0]  rx_len;
  logic             rx_gnt;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport master (
    output tx_req, tx_len, tx_data, rx_req, rx_len,
    input  tx_gnt, tx_rd, rx_gnt, rx_data, rx_valid
  );

  modport slave (
    input  tx_req, tx_len, tx_data, rx_req, rx_len,
    output tx_gnt, tx_rd, rx_gnt, rx_data, rx_valid
  );

endinterface

// File: rtl/pad_valid_pipe.sv
// DEPTH-deep valid shift register with the pad input captured alongside its head.
// Synchronous active-low clear drops every in-flight valid bit.
module pad_valid_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0] sr;
  logic [DEPTH-1:0] sr_nxt;
  logic             head_in;

  generate
    if (DEPTH == 1) begin : g_depth1
      assign sr_nxt  = push;
      assign head_in = push;
    end else begin : g_depthn
      assign sr_nxt  = {sr[DEPTH-2:0], push};
      assign head_in = sr[DEPTH-2];
    end
  endgenerate

  // Data is only captured when a valid bit is about to reach the head.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      sr   <= '0;
      dout <= '0;
    end else begin
      sr <= sr_nxt;
      if (head_in) begin
        dout <= din;
      end
    end
  end

  assign valid = sr[DEPTH-1];

endmodule

// File: rtl/pad_dir_sched.sv
// Half-duplex direction scheduler for a bank of registered bidir pads sharing one oe.
// Arbitrates TX/RX bursts, inserts a turnaround gap on direction changes, tags RX samples.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | evaluate requests, grant one, pick TURN or go straight in
// TURN    | bus turnaround, oe low, nothing sampled, TURN cycles long
// TX      | one tx_rd beat per cycle, count 0 is the last beat
// RX      | one sample cycle per beat, count 0 is the last beat
module pad_dir_sched
  import pad_dir_sched_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENW   = 8,
  parameter int TURN   = TURN_DEF,
  parameter int IN_LAT = IN_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_l,
  pad_dir_sched_if.slave        bus,
  output logic [WIDTH-1:0]      pad_o,
  output logic                  pad_oe,
  input  logic [WIDTH-1:0]      pad_i,
  output logic                  busy
);

  localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN - 1);

  state_t                state, state_nxt;
  dir_t                  last_dir, last_dir_nxt;
  logic [LENW-1:0]       beat_cnt, beat_cnt_nxt;
  logic [TURN_CNT_W-1:0] turn_cnt, turn_cnt_nxt;

  dir_t       req_dir;
  logic       tx_gnt;
  logic       rx_gnt;
  logic       tx_rd;
  logic       sample;
  logic       rx_valid;
  logic [WIDTH-1:0] rx_data;

  assign req_dir = pick_dir(bus.tx_req, bus.rx_req, last_dir);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state    <= ST_IDLE;
      last_dir <= DIR_NONE;
      beat_cnt <= '0;
      turn_cnt <= '0;
      pad_oe   <= 1'b0;
      pad_o    <= '0;
    end else begin
      state    <= state_nxt;
      last_dir <= last_dir_nxt;
      beat_cnt <= beat_cnt_nxt;
      turn_cnt <= turn_cnt_nxt;
      pad_oe   <= tx_rd;
      if (tx_rd) begin
        pad_o <= bus.tx_data;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir;
    beat_cnt_nxt = beat_cnt;
    turn_cnt_nxt = turn_cnt;
    tx_gnt       = 1'b0;
    rx_gnt       = 1'b0;
    tx_rd        = 1'b0;
    sample       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_dir != DIR_NONE) begin
          tx_gnt       = (req_dir == DIR_TX);
          rx_gnt       = (req_dir == DIR_RX);
          beat_cnt_nxt = (req_dir == DIR_TX) ? bus.tx_len : bus.rx_len;
          last_dir_nxt = req_dir;
          // last_dir doubles as the pending direction while in TURN.
          if ((last_dir != DIR_NONE) && (last_dir != req_dir)) begin
            state_nxt    = ST_TURN;
            turn_cnt_nxt = TURN_LOAD;
          end else begin
            state_nxt = (req_dir == DIR_TX) ? ST_TX : ST_RX;
          end
        end
      end

      ST_TURN: begin
        if (turn_cnt == '0) begin
          state_nxt = (last_dir == DIR_TX) ? ST_TX : ST_RX;
        end else begin
          turn_cnt_nxt = turn_cnt - 1'b1;
        end
      end

      ST_TX: begin
        tx_rd = 1'b1;
        if (beat_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          beat_cnt_nxt = beat_cnt - 1'b1;
        end
      end

      ST_RX: begin
        sample = 1'b1;
        if (beat_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          beat_cnt_nxt = beat_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  pad_valid_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (IN_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .reset_l (reset_l),
    .push    (sample),
    .din     (pad_i),
    .valid   (rx_valid),
    .dout    (rx_data)
  );

  assign bus.tx_gnt   = tx_gnt;
  assign bus.rx_gnt   = rx_gnt;
  assign bus.tx_rd    = tx_rd;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data;
  assign busy         = (state != ST_IDLE);

endmodule
